// File: rtl/argon_alu_seq.sv
// -----------------------------------------------------------------------------
// argon_alu_seq
//
// Sequencer that drives one operation through a strobe-controlled ALU over a
// shared 16-bit bus. It accepts a request (op, a, b, optional flag preload),
// writes the operands and opcode into the ALU, waits one cycle while the ALU
// registers its result, then reads Y and the flags back. The result is held
// in a response buffer until the consumer takes it.
//
// State sequence:
//   IDLE -> WR_A -> WR_B -> [WR_F] -> WR_OP -> EXEC -> RD_Y -> RD_F -> RESP
//
// Configuration macro:
//   ARGON_ALU_SEQ_FLAGS_EN  defined   : WR_F state and flag preload are built.
//                           undefined : i_req_use_flags / i_req_flags are
//                                       ignored and o_latchF is tied low.
//
// Ports:
//   i_Clk, i_Reset_n            clock, synchronous active-low reset
//   i_req_valid / o_req_ready   request handshake (ready only in IDLE)
//   i_req_op, i_req_a, i_req_b  opcode and operands
//   i_req_use_flags, i_req_flags  optional flag register preload
//   o_rsp_valid / i_rsp_ready   response handshake
//   o_rsp_y, o_rsp_flags, o_rsp_err  result, flags, bus-invalid error
//   o_bus_data / i_bus_data     ALU bus out / in
//   i_bus_valid                 ALU bus-output valid qualifier
//   o_latchA/B/F/Op             ALU input register strobes
//   o_outputY/F                 ALU output-select strobes
//   o_busy                      high whenever not IDLE
// -----------------------------------------------------------------------------
module argon_alu_seq (
  input  logic        i_Clk,
  input  logic        i_Reset_n,
  // request
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [3:0]  i_req_op,
  input  logic [15:0] i_req_a,
  input  logic [15:0] i_req_b,
  input  logic        i_req_use_flags,
  input  logic [15:0] i_req_flags,
  // response
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_y,
  output logic [15:0] o_rsp_flags,
  output logic        o_rsp_err,
  // ALU side
  output logic [15:0] o_bus_data,
  input  logic [15:0] i_bus_data,
  input  logic        i_bus_valid,
  output logic        o_latchA,
  output logic        o_latchB,
  output logic        o_latchF,
  output logic        o_latchOp,
  output logic        o_outputY,
  output logic        o_outputF,
  output logic        o_busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_WR_F,
    S_WR_OP,
    S_EXEC,
    S_RD_Y,
    S_RD_F,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [15:0] rsp_y_q, rsp_flags_q;
  logic        rsp_err_q;
  logic        accept;

`ifdef ARGON_ALU_SEQ_FLAGS_EN
  logic        use_flags_q;
  logic [15:0] flags_q;
`else
  // Preload inputs have no function in this build; fold them into a sink.
  logic        unused_flag_inputs;
  assign unused_flag_inputs = ^{i_req_use_flags, i_req_flags};
`endif

  assign accept = i_req_valid & o_req_ready;

  // ---------------------------------------------------------------------------
  // State and response registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples values from before the edge regardless of order.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      state_q     <= S_IDLE;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      // Data is captured even when the bus is flagged invalid; the error bit
      // tells the consumer not to trust it.
      if (state_q == S_RD_Y) begin
        rsp_y_q <= i_bus_data;
        if (!i_bus_valid) rsp_err_q <= 1'b1;
      end
      if (state_q == S_RD_F) begin
        rsp_flags_q <= i_bus_data;
        if (!i_bus_valid) rsp_err_q <= 1'b1;
      end
      // Error stays set until the response carrying it is consumed.
      if (state_q == S_RESP && i_rsp_ready) rsp_err_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Request capture
  // ---------------------------------------------------------------------------
  // NOTE: operand registers carry no reset; they are always loaded on accept
  // before anything reads them, so a reset term would only add fan-in.
  always_ff @(posedge i_Clk) begin
    if (accept) begin
      op_q <= i_req_op;
      a_q  <= i_req_a;
      b_q  <= i_req_b;
`ifdef ARGON_ALU_SEQ_FLAGS_EN
      use_flags_q <= i_req_use_flags;
      flags_q     <= i_req_flags;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and strobes
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_latchA    = 1'b0;
    o_latchB    = 1'b0;
    o_latchF    = 1'b0;
    o_latchOp   = 1'b0;
    o_outputY   = 1'b0;
    o_outputF   = 1'b0;
    o_bus_data  = '0;

    unique case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = S_WR_A;
      end
      S_WR_A: begin
        o_latchA   = 1'b1;
        o_bus_data = a_q;
        state_d    = S_WR_B;
      end
      S_WR_B: begin
        o_latchB   = 1'b1;
        o_bus_data = b_q;
`ifdef ARGON_ALU_SEQ_FLAGS_EN
        state_d    = use_flags_q ? S_WR_F : S_WR_OP;
`else
        state_d    = S_WR_OP;
`endif
      end
      S_WR_F: begin
`ifdef ARGON_ALU_SEQ_FLAGS_EN
        o_latchF   = 1'b1;
        o_bus_data = flags_q;
        state_d    = S_WR_OP;
`else
        state_d    = S_IDLE;  // unreachable in this build
`endif
      end
      S_WR_OP: begin
        o_latchOp  = 1'b1;
        o_bus_data = {12'h000, op_q};
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        // All strobes low: the ALU registers its result this cycle.
        state_d = S_RD_Y;
      end
      S_RD_Y: begin
        // Re-latching the same opcode keeps the ALU from recomputing with the
        // carry it just produced, so Y and flags stay frozen during readout.
        o_outputY  = 1'b1;
        o_latchOp  = 1'b1;
        o_bus_data = {12'h000, op_q};
        state_d    = S_RD_F;
      end
      S_RD_F: begin
        o_outputF  = 1'b1;
        o_latchOp  = 1'b1;
        o_bus_data = {12'h000, op_q};
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_y     = rsp_y_q;
  assign o_rsp_flags = rsp_flags_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_argon_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_argon_alu_seq
//
// Directed bench for argon_alu_seq. A small behavioural ALU answers the
// strobes: operands/flags/opcode are registered on their latch strobes, the
// result is computed on the cycle where the sequencer is busy with every
// strobe low (EXEC), and Y / flags are placed on the bus when selected.
// ALU flag layout used here: bit0 = carry, bit1 = zero.
// Latency is counted in cycles after the accepting edge: the first cycle after
// acceptance is cycle 1; o_rsp_valid must first be seen in cycle 7 (8 with WR_F).
// -----------------------------------------------------------------------------
module tb_argon_alu_seq;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_ADC = 4'h1;
  localparam logic [3:0] ALU_XOR = 4'h4;

  localparam logic [31:0] SEQ_NO_F   = 32'h0012_4056;  // A,B,Op,-,Y,F
  localparam logic [31:0] SEQ_WITH_F = 32'h0123_4056;  // A,B,F,Op,-,Y,F

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_use_flags;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b, req_flags;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_y, rsp_flags;
  logic [15:0] bus_out, bus_in;
  logic        bus_valid;
  logic        latch_a, latch_b, latch_f, latch_op, output_y, output_f, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  logic        bus_fault = 1'b0;
  logic [3:0]  cur_op;
  logic [15:0] cur_a, cur_b, cur_f;

  always #5 clk = ~clk;

  argon_alu_seq dut (
    .i_Clk          (clk),
    .i_Reset_n      (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_op       (req_op),
    .i_req_a        (req_a),
    .i_req_b        (req_b),
    .i_req_use_flags(req_use_flags),
    .i_req_flags    (req_flags),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_y        (rsp_y),
    .o_rsp_flags    (rsp_flags),
    .o_rsp_err      (rsp_err),
    .o_bus_data     (bus_out),
    .i_bus_data     (bus_in),
    .i_bus_valid    (bus_valid),
    .o_latchA       (latch_a),
    .o_latchB       (latch_b),
    .o_latchF       (latch_f),
    .o_latchOp      (latch_op),
    .o_outputY      (output_y),
    .o_outputF      (output_f),
    .o_busy         (busy)
  );

  // ---------------- behavioural ALU ----------------
  logic [15:0] alu_a = '0, alu_b = '0, alu_f = '0, alu_y = '0;
  logic [3:0]  alu_op = '0;
  logic [16:0] alu_sum;

  always @(posedge clk) begin
    if (latch_a)  alu_a  <= bus_out;
    if (latch_b)  alu_b  <= bus_out;
    if (latch_f)  alu_f  <= bus_out;
    if (latch_op) alu_op <= bus_out[3:0];
    if (busy && !(latch_a || latch_b || latch_f || latch_op || output_y || output_f)) begin
      case (alu_op)
        ALU_ADD: alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        ALU_ADC: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_f[0]};
        ALU_XOR: alu_sum = {1'b0, alu_a ^ alu_b};
        default: alu_sum = '0;
      endcase
      alu_y <= alu_sum[15:0];
      alu_f <= {14'h0, (alu_sum[15:0] == 16'h0), alu_sum[16]};
    end
  end

  assign bus_in    = output_y ? alu_y : (output_f ? alu_f : 16'h0000);
  assign bus_valid = !(bus_fault && output_y);

  // ---------------- per-cycle protocol monitor ----------------
  always @(negedge clk) begin : mon
    int bad;
    int nl;
    bad = 0;
    nl  = int'(latch_a) + int'(latch_b) + int'(latch_f) + int'(latch_op);
    if (nl > 1) bad++;
    if (output_y && output_f) bad++;
    if ((output_y || output_f) && !latch_op) bad++;
    if (nl == 0 && bus_out !== 16'h0000) bad++;
    if (latch_a && bus_out !== cur_a) bad++;
    if (latch_b && bus_out !== cur_b) bad++;
    if (latch_f && bus_out !== cur_f) bad++;
    if (latch_op && bus_out !== {12'h000, cur_op}) bad++;
`ifndef ARGON_ALU_SEQ_FLAGS_EN
    if (latch_f) bad++;
`endif
    viol <= viol + bad;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] strobe_code();
    if (latch_a)       return 4'h1;
    else if (latch_b)  return 4'h2;
    else if (latch_f)  return 4'h3;
    else if (output_y) return 4'h5;
    else if (output_f) return 4'h6;
    else if (latch_op) return 4'h4;
    else               return 4'h0;
  endfunction

  task automatic send_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic uf, input logic [15:0] fl);
    int guard;
    cur_op = op; cur_a = a; cur_b = b; cur_f = fl;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_use_flags = uf; req_flags = fl;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic uf, input logic [15:0] fl, input int hold, input logic fault,
                         output logic [15:0] y, output logic [15:0] f, output logic err,
                         output int lat, output logic [31:0] seq, output int unstable);
    send_req(op, a, b, uf, fl);
    bus_fault = fault;
    lat = 0;
    seq = '0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid) seq = {seq[27:0], strobe_code()};
    end while (!rsp_valid && lat < 20);
    bus_fault = 1'b0;
    y = rsp_y; f = rsp_flags; err = rsp_err;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_y !== y || rsp_flags !== f || rsp_err !== err || rsp_valid !== 1'b1 || req_ready !== 1'b0)
        unstable++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("idle_after_handshake", {29'h0, rsp_valid, busy, req_ready}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] y, f;
    logic        err;
    int          lat, unstable, seen;
    logic [31:0] seq;

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_use_flags = 1'b0; req_flags = '0;
    cur_op = '0; cur_a = '0; cur_b = '0; cur_f = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_strobes", {26'h0, latch_a, latch_b, latch_f, latch_op, output_y, output_f}, 32'h0);
    check("rst_busy_valid_err", {29'h0, busy, rsp_valid, rsp_err}, 32'h0);
    check("rst_rsp_y", 32'(rsp_y), 32'h0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'h0);
    check("rst_bus_data", 32'(bus_out), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);

    // ADD 3 + 4
    run_req(ALU_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0000, 0, 1'b0, y, f, err, lat, seq, unstable);
    check("add_y", 32'(y), 32'h0007);
    check("add_flags", 32'(f), 32'h0000);
    check("add_err", 32'(err), 32'h0);
    check("add_latency", 32'(lat), 32'd7);
    check("add_strobe_seq", seq, SEQ_NO_F);

    // ADC 0xFFFF + 0 with carry preload
    run_req(ALU_ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0001, 0, 1'b0, y, f, err, lat, seq, unstable);
`ifdef ARGON_ALU_SEQ_FLAGS_EN
    check("adc_y", 32'(y), 32'h0000);
    check("adc_flags", 32'(f), 32'h0003);
    check("adc_latency", 32'(lat), 32'd8);
    check("adc_strobe_seq", seq, SEQ_WITH_F);
`else
    // Preload ignored: carry-in is the carry left by the ADD above (0).
    check("adc_y", 32'(y), 32'hFFFF);
    check("adc_flags", 32'(f), 32'h0000);
    check("adc_latency", 32'(lat), 32'd7);
    check("adc_strobe_seq", seq, SEQ_NO_F);
`endif
    check("adc_err", 32'(err), 32'h0);

    // Consumer stalls 5 cycles in RESP
    run_req(ALU_ADD, 16'h1234, 16'h1111, 1'b0, 16'h0000, 5, 1'b0, y, f, err, lat, seq, unstable);
    check("stall_y", 32'(y), 32'h2345);
    check("stall_outputs_stable", 32'(unstable), 32'd0);

    // Bus invalid during RD_Y
    run_req(ALU_XOR, 16'hAAAA, 16'h5555, 1'b0, 16'h0000, 0, 1'b1, y, f, err, lat, seq, unstable);
    check("fault_err", 32'(err), 32'h1);
    check("fault_y_captured", 32'(y), 32'hFFFF);

    // Clean request clears the error; 0x8000+0x8000 wraps to zero with carry
    run_req(ALU_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 0, 1'b0, y, f, err, lat, seq, unstable);
    check("clean_err", 32'(err), 32'h0);
    check("wrap_y", 32'(y), 32'h0000);
    check("wrap_flags", 32'(f), 32'h0003);

    // Reset during EXEC abandons the operation
    send_req(ALU_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0000);
    repeat (4) @(negedge clk);
    check("exec_reached", {25'h0, busy, latch_a, latch_b, latch_f, latch_op, output_y, output_f}, 32'h40);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", {29'h0, busy, rsp_valid, req_ready}, 32'h1);
    check("midrst_strobes", {26'h0, latch_a, latch_b, latch_f, latch_op, output_y, output_f}, 32'h0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("midrst_no_response", 32'(seen), 32'd0);

    run_req(ALU_XOR, 16'h00FF, 16'h0F0F, 1'b0, 16'h0000, 0, 1'b0, y, f, err, lat, seq, unstable);
    check("xor_after_rst_y", 32'(y), 32'h0FF0);
    check("xor_after_rst_err", 32'(err), 32'h0);

    @(negedge clk);
    check("protocol_violations", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/argon_alu_seq.md
ARGON_ALU_SEQ -- requirements
Module: argon_alu_seq

Interface
REQ-001 SHALL have ports: i_Clk  in  1  sole clock; all state on its rising edge.
REQ-002 SHALL have ports: i_Reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have request ports: i_req_valid in 1; o_req_ready out 1; i_req_op in 4 (argon_pkg ALU opcode, passed through unmodified); i_req_a in 16; i_req_b in 16; i_req_use_flags in 1; i_req_flags in 16.
REQ-004 SHALL have response ports: o_rsp_valid out 1; i_rsp_ready in 1; o_rsp_y out 16; o_rsp_flags out 16; o_rsp_err out 1.
REQ-005 SHALL have ALU-side ports: o_bus_data out 16 (to ALU bus input); i_bus_data in 16 (from ALU bus output); i_bus_valid in 1; o_latchA, o_latchB, o_latchF, o_latchOp, o_outputY, o_outputF out 1 each; o_busy out 1.

Function
REQ-006 SHALL act as the sole initiator driving the ALU control strobes, with states IDLE, WR_A, WR_B, WR_F, WR_OP, EXEC, RD_Y, RD_F, RESP.
REQ-007 SHALL assert o_req_ready only in IDLE; a request is accepted on a rising edge with i_req_valid & o_req_ready, capturing op/a/b/use_flags/flags into internal registers.
REQ-008 SHALL sequence: IDLE -> WR_A -> WR_B -> (WR_F if captured use_flags) -> WR_OP -> EXEC -> RD_Y -> RD_F -> RESP, one cycle per state except RESP.
REQ-009 SHALL assert at most one of o_latchA/B/F/Op per cycle: WR_A: o_latchA, o_bus_data=a; WR_B: o_latchB, o_bus_data=b; WR_F: o_latchF, o_bus_data=flags; WR_OP: o_latchOp, o_bus_data={12'h000, op}.
REQ-010 EXEC SHALL drive all latch and output strobes low for exactly one cycle so the ALU registers its result.
REQ-011 RD_Y SHALL assert o_outputY and RD_F SHALL assert o_outputF; in both, o_latchOp SHALL be asserted with o_bus_data={12'h000, op} so the ALU does not recompute (freezes carry-dependent results).
REQ-012 SHALL sample i_bus_data into o_rsp_y at the end of RD_Y and into o_rsp_flags at the end of RD_F.
REQ-013 SHALL set o_rsp_err if i_bus_valid is low at either sample edge; error is sticky until the response is consumed; data is still captured.
REQ-014 SHALL hold o_rsp_valid high in RESP, with o_rsp_y/flags/err stable, until i_rsp_ready; on handshake return to IDLE (no back-to-back accept in the same cycle).
REQ-015 o_bus_data SHALL be 16'h0000 in every state not listed in REQ-009/REQ-011.
REQ-016 o_busy SHALL be high in every state except IDLE.
REQ-017 Latency: with use_flags=0, o_rsp_valid rises 7 cycles after the accepting edge; with WR_F, 8 cycles.

Reset
REQ-018 On a rising edge with i_Reset_n low, SHALL enter IDLE; all strobes, o_rsp_valid, o_rsp_err, o_busy low; o_rsp_y, o_rsp_flags, o_bus_data zero.
REQ-019 Reset mid-sequence SHALL abandon the operation without a response; strobes low from the following cycle.

Configuration
REQ-020 Macro ARGON_ALU_SEQ_FLAGS_EN: defined -> WR_F state and flag preload implemented per REQ-008/009; undefined -> i_req_use_flags and i_req_flags ignored, WR_F never entered, o_latchF tied 0, latency always 7.

Verification
REQ-021 ALU_ADD a=16'h0003 b=16'h0004, use_flags=0 -> strobes A,B,Op,-,Y,F in order; o_rsp_y=16'h0007, carry=0, zero=0, err=0, rsp_valid 7 cycles after accept.
REQ-022 ALU_ADC a=16'hFFFF b=16'h0000, use_flags=1 flags carry=1 (FLAGS_EN) -> WR_F seen, o_rsp_y=16'h0000, carry=1, zero=1, latency 8.
REQ-023 i_rsp_ready held low 5 cycles in RESP -> outputs stable, o_req_ready=0; accepts next request only after return to IDLE.
REQ-024 i_bus_valid forced low during RD_Y -> o_rsp_err=1; next clean request -> o_rsp_err=0.
REQ-025 i_Reset_n low during EXEC -> next cycle IDLE, all strobes 0, no o_rsp_valid; subsequent ALU_XOR 16'h00FF^16'h0F0F -> o_rsp_y=16'h0FF0.
REQ-026 Every cycle of all runs -> at most one latch strobe high, and o_outputY/o_outputF never both high.
